// File: rtl/lv_reg_bank_if.sv
// SPI-slave to register-bank request/response bus.
// The master side (SPI slave) raises one-cycle requests; the bank answers with one-cycle acks.
interface lv_reg_bank_if;
    logic       i_spi_reg_wr_req;
    logic       i_spi_reg_rd_req;
    logic [6:0] i_spi_reg_addr;
    logic [7:0] i_spi_reg_wdata;
    logic [7:0] i_spi_reg_wcrc;
    logic       o_reg_spi_wack;
    logic       o_reg_spi_rack;
    logic [7:0] o_reg_spi_data;
    logic [6:0] o_reg_spi_addr;
    logic       o_reg_crc_err;
    logic       o_reg_req_err;

    modport master (
        output i_spi_reg_wr_req, i_spi_reg_rd_req, i_spi_reg_addr, i_spi_reg_wdata, i_spi_reg_wcrc,
        input  o_reg_spi_wack, o_reg_spi_rack, o_reg_spi_data, o_reg_spi_addr,
               o_reg_crc_err, o_reg_req_err
    );

    modport slave (
        input  i_spi_reg_wr_req, i_spi_reg_rd_req, i_spi_reg_addr, i_spi_reg_wdata, i_spi_reg_wcrc,
        output o_reg_spi_wack, o_reg_spi_rack, o_reg_spi_data, o_reg_spi_addr,
               o_reg_crc_err, o_reg_req_err
    );
endinterface

// File: rtl/lv_reg_bank.sv
// 8-bit register bank behind an SPI slave: CRC-8 (poly 0x07) protected writes,
// one-cycle reads, chip-ID at 0x00 and a saturating CRC-error counter in the top register.
module lv_reg_bank #(
    parameter int          REG_NUM = 16,
    parameter logic [7:0]  CHIP_ID = 8'hA5
) (
    input  logic           i_clk,
    input  logic           i_rst,
    lv_reg_bank_if.slave   bus,
    output logic [7:0]     o_cfg0,
    output logic [7:0]     o_cfg1
);
    localparam logic [6:0] STAT_ADDR = 7'(REG_NUM - 1);

    typedef enum logic [1:0] {IDLE, RD, CRC, WR} state_t;

    state_t      state, state_nxt;
    logic [6:0]  waddr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  wcrc_q;
    logic [7:0]  crc_q;
    logic [3:0]  bit_cnt;
    logic [7:0]  err_cnt;
    logic        busy_err_q;
    logic [7:0]  rdata_q;
    logic [6:0]  raddr_q;

    logic        wr_go, rd_go, crc_ok, waddr_rw, do_write, do_clear, do_crc_err;
    logic        waddr_bad, raddr_bad;
    logic [15:0] msg;
    logic        fb;
    logic [7:0]  crc_step;
    logic [7:0]  rd_sel;
    logic [7:0]  rd_view [REG_NUM];

    // Write wins a simultaneous request; the read is dropped.
    assign wr_go = (state == IDLE) && bus.i_spi_reg_wr_req;
    assign rd_go = (state == IDLE) && bus.i_spi_reg_rd_req && !bus.i_spi_reg_wr_req;

    assign msg      = {1'b1, waddr_q, wdata_q};
    assign fb       = crc_q[7] ^ msg[4'd15 - bit_cnt];
    assign crc_step = {crc_q[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    assign crc_ok   = (crc_q == wcrc_q);

    assign waddr_bad  = (waddr_q == 7'd0) || (int'(waddr_q) >= REG_NUM);
    assign raddr_bad  = (int'(raddr_q) >= REG_NUM);
    assign waddr_rw   = !waddr_bad && (waddr_q != STAT_ADDR);
    assign do_write   = (state == WR) && crc_ok && waddr_rw;
    assign do_clear   = (state == WR) && crc_ok && (waddr_q == STAT_ADDR);
    assign do_crc_err = (state == WR) && !crc_ok;

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_go)      state_nxt = CRC;
                else if (rd_go) state_nxt = RD;
            end
            RD:  state_nxt = IDLE;
            CRC: if (bit_cnt == 4'd15) state_nxt = WR;
            WR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.o_reg_spi_wack = (state == WR) && crc_ok;
        bus.o_reg_crc_err  = (state == WR) && !crc_ok;
        bus.o_reg_spi_rack = (state == RD);
        bus.o_reg_req_err  = busy_err_q
                           || ((state == IDLE) && bus.i_spi_reg_wr_req && bus.i_spi_reg_rd_req && !i_rst)
                           || ((state == WR) && crc_ok && waddr_bad)
                           || ((state == RD) && raddr_bad);
    end

    assign bus.o_reg_spi_data = rdata_q;
    assign bus.o_reg_spi_addr = raddr_q;

    // Read mux on the live request address so data is ready alongside rack.
    always_comb begin
        rd_sel = 8'h00;
        for (int i = 0; i < REG_NUM; i++)
            if (bus.i_spi_reg_addr == 7'(i)) rd_sel = rd_view[i];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            waddr_q    <= '0;
            wdata_q    <= '0;
            wcrc_q     <= '0;
            crc_q      <= '0;
            bit_cnt    <= '0;
            err_cnt    <= '0;
            busy_err_q <= 1'b0;
            rdata_q    <= '0;
            raddr_q    <= '0;
        end else begin
            busy_err_q <= (state != IDLE) && (bus.i_spi_reg_wr_req || bus.i_spi_reg_rd_req);
            if (wr_go) begin
                waddr_q <= bus.i_spi_reg_addr;
                wdata_q <= bus.i_spi_reg_wdata;
                wcrc_q  <= bus.i_spi_reg_wcrc;
                crc_q   <= 8'h00;
                bit_cnt <= 4'd0;
            end else if (rd_go) begin
                raddr_q <= bus.i_spi_reg_addr;
                rdata_q <= rd_sel;
            end
            if (state == CRC) begin
                crc_q   <= crc_step;
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (do_crc_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            else if (do_clear)                  err_cnt <= 8'h00;
        end
    end

    assign rd_view[0]         = CHIP_ID;
    assign rd_view[REG_NUM-1] = err_cnt;

    for (genvar i = 1; i < REG_NUM - 1; i++) begin : g_rw
        logic [7:0] r;
        always_ff @(posedge i_clk) begin
            if (i_rst)                               r <= 8'h00;
            else if (do_write && waddr_q == 7'(i))   r <= wdata_q;
        end
        assign rd_view[i] = r;
    end

    assign o_cfg0 = rd_view[1];
    assign o_cfg1 = rd_view[2];
endmodule

// File: tb/tb_lv_reg_bank.sv
// Randomized self-checking bench for lv_reg_bank against a behavioural register-map model.
module tb_lv_reg_bank;
    localparam int NR = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] cfg0, cfg1;
    lv_reg_bank_if bus();

    lv_reg_bank #(.REG_NUM(NR), .CHIP_ID(8'hA5)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus), .o_cfg0(cfg0), .o_cfg1(cfg1)
    );

    always #5 clk = ~clk;

    int npass = 0, nchk = 0;

    // Behavioural model of the register map
    logic [7:0] mregs [128];
    logic [7:0] mcnt;

    // Per-operation observation (bit k = output seen in cycle T+k)
    logic [19:0] wack_m, crc_m, rack_m, err_m;
    logic [7:0]  rdat;
    logic [6:0]  radr;
    logic [7:0]  cfg0_h [20];

    function automatic logic [7:0] crc8(input logic [6:0] a, input logic [7:0] d);
        logic [15:0] m;
        logic [7:0]  c;
        m = {1'b1, a, d};
        c = 8'h00;
        for (int i = 15; i >= 0; i--)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ m[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    function automatic logic [7:0] m_read(input logic [6:0] a);
        if (a == 0)        return 8'hA5;
        if (a == NR - 1)   return mcnt;
        if (int'(a) < NR)  return mregs[a];
        return 8'h00;
    endfunction

    // Applies a write to the model; returns {crc_err, wack, req_err} expected at T+17.
    function automatic logic [2:0] m_write(input logic [6:0] a, input logic [7:0] d, input logic [7:0] c);
        if (crc8(a, d) != c) begin
            if (mcnt != 8'hFF) mcnt = mcnt + 8'd1;
            return 3'b100;
        end
        if (a == 0 || int'(a) >= NR) return 3'b011;
        if (a == NR - 1) mcnt = 8'h00;
        else             mregs[a] = d;
        return 3'b010;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.i_spi_reg_wr_req = 1'b0;
        bus.i_spi_reg_rd_req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 128; i++) mregs[i] = 8'h00;
        mcnt = 8'h00;
    endtask

    // Drives one request in cycle T and watches 20 cycles; optional extra read pulse and reset.
    task automatic run_op(input bit wr, input bit rd, input logic [6:0] a, input logic [7:0] d,
                          input logic [7:0] c, input int inj_k, input int rst_k);
        wack_m = '0; crc_m = '0; rack_m = '0; err_m = '0;
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            #1;
            bus.i_spi_reg_wr_req = (k == 0) && wr;
            bus.i_spi_reg_rd_req = ((k == 0) && rd) || (inj_k > 0 && k == inj_k);
            bus.i_spi_reg_addr   = a;
            bus.i_spi_reg_wdata  = d;
            bus.i_spi_reg_wcrc   = c;
            rst = (rst_k > 0 && k == rst_k);
            @(negedge clk);
            wack_m[k] = bus.o_reg_spi_wack;
            crc_m[k]  = bus.o_reg_crc_err;
            rack_m[k] = bus.o_reg_spi_rack;
            err_m[k]  = bus.o_reg_req_err;
            cfg0_h[k] = cfg0;
            if (bus.o_reg_spi_rack) begin
                rdat = bus.o_reg_spi_data;
                radr = bus.o_reg_spi_addr;
            end
            @(posedge clk);
        end
        #1;
        bus.i_spi_reg_wr_req = 1'b0;
        bus.i_spi_reg_rd_req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        nchk++;
        if ({bus.o_reg_spi_wack, bus.o_reg_spi_rack, bus.o_reg_crc_err, bus.o_reg_req_err,
             bus.o_reg_spi_data, bus.o_reg_spi_addr, cfg0, cfg1} !== '0)
            $display("FAIL reset_outputs got wack%b rack%b crc%b err%b data%h addr%h cfg%h/%h exp all zero",
                     bus.o_reg_spi_wack, bus.o_reg_spi_rack, bus.o_reg_crc_err, bus.o_reg_req_err,
                     bus.o_reg_spi_data, bus.o_reg_spi_addr, cfg0, cfg1);
        else npass++;
        run_op(0, 1, 7'(NR - 1), 8'h00, 8'h00, 0, 0);
        nchk++;
        if ({rack_m, rdat} !== {20'h2, 8'h00})
            $display("FAIL reset_status rack=%h data=%h exp rack=00002 data=00", rack_m, rdat);
        else npass++;
    endtask

    task automatic test_good_write();
        logic [2:0] e;
        e = m_write(7'h01, 8'h5A, 8'h22);
        run_op(1, 0, 7'h01, 8'h5A, 8'h22, 0, 0);
        nchk++;
        if ({crc_m, wack_m, err_m} !== {(e[2] ? 20'h20000 : 20'h0), (e[1] ? 20'h20000 : 20'h0), 20'h0})
            $display("FAIL good_write crc=%h wack=%h err=%h exp wack=20000 only", crc_m, wack_m, err_m);
        else npass++;
        nchk++;
        if ({cfg0_h[17], cfg0_h[18]} !== {8'h00, 8'h5A})
            $display("FAIL good_write_cfg0 T17=%h T18=%h exp 00 5a", cfg0_h[17], cfg0_h[18]);
        else npass++;
    endtask

    task automatic test_bad_crc();
        logic [2:0] e;
        e = m_write(7'h01, 8'h5A, 8'h23);
        run_op(1, 0, 7'h01, 8'h5A, 8'h23, 0, 0);
        nchk++;
        if ({crc_m, wack_m, err_m, e} !== {20'h20000, 20'h0, 20'h0, 3'b100})
            $display("FAIL bad_crc crc=%h wack=%h err=%h exp crc=20000 only", crc_m, wack_m, err_m);
        else npass++;
        nchk++;
        if (cfg0 !== 8'h5A) $display("FAIL bad_crc_cfg0 got %h exp 5a", cfg0);
        else npass++;
        run_op(0, 1, 7'h0F, 8'h00, 8'h00, 0, 0);
        nchk++;
        if ({rack_m, rdat, radr} !== {20'h2, 8'h01, 7'h0F})
            $display("FAIL bad_crc_status rack=%h data=%h addr=%h exp 00002 01 0f", rack_m, rdat, radr);
        else npass++;
    endtask

    task automatic test_reads();
        logic [2:0] e;
        run_op(0, 1, 7'h00, 8'h00, 8'h00, 0, 0);
        nchk++;
        if ({rack_m, err_m, rdat, radr} !== {20'h2, 20'h0, 8'hA5, 7'h00})
            $display("FAIL read_chipid rack=%h err=%h data=%h addr=%h exp 00002 00000 a5 00",
                     rack_m, err_m, rdat, radr);
        else npass++;
        run_op(0, 1, 7'h20, 8'h00, 8'h00, 0, 0);
        nchk++;
        if ({rack_m, err_m, rdat, radr} !== {20'h2, 20'h2, 8'h00, 7'h20})
            $display("FAIL read_oor rack=%h err=%h data=%h addr=%h exp 00002 00002 00 20",
                     rack_m, err_m, rdat, radr);
        else npass++;
        // Legal-CRC write to the read-only chip ID
        e = m_write(7'h00, 8'h77, crc8(7'h00, 8'h77));
        run_op(1, 0, 7'h00, 8'h77, crc8(7'h00, 8'h77), 0, 0);
        nchk++;
        if ({wack_m, err_m, crc_m, e} !== {20'h20000, 20'h20000, 20'h0, 3'b011})
            $display("FAIL write_ro wack=%h err=%h crc=%h exp 20000 20000 00000", wack_m, err_m, crc_m);
        else npass++;
        run_op(0, 1, 7'h00, 8'h00, 8'h00, 0, 0);
        nchk++;
        if (rdat !== 8'hA5) $display("FAIL read_ro_after got %h exp a5", rdat);
        else npass++;
    endtask

    task automatic test_collisions();
        logic [2:0] e;
        e = m_write(7'h02, 8'h33, crc8(7'h02, 8'h33));
        run_op(1, 1, 7'h02, 8'h33, crc8(7'h02, 8'h33), 0, 0);
        nchk++;
        if ({err_m, wack_m, rack_m, crc_m} !== {20'h1, 20'h20000, 20'h0, 20'h0})
            $display("FAIL collide_same err=%h wack=%h rack=%h crc=%h exp 00001 20000 0 0",
                     err_m, wack_m, rack_m, crc_m);
        else npass++;
        nchk++;
        if (cfg1 !== mregs[2]) $display("FAIL collide_cfg1 got %h exp %h", cfg1, mregs[2]);
        else npass++;
        e = m_write(7'h03, 8'hC4, crc8(7'h03, 8'hC4));
        run_op(1, 0, 7'h03, 8'hC4, crc8(7'h03, 8'hC4), 5, 0);
        nchk++;
        if ({err_m, wack_m, rack_m} !== {20'h40, 20'h20000, 20'h0})
            $display("FAIL collide_busy err=%h wack=%h rack=%h exp 00040 20000 0", err_m, wack_m, rack_m);
        else npass++;
        run_op(0, 1, 7'h03, 8'h00, 8'h00, 0, 0);
        nchk++;
        if (rdat !== m_read(7'h03)) $display("FAIL collide_busy_rd got %h exp %h", rdat, m_read(7'h03));
        else npass++;
    endtask

    task automatic test_random();
        logic [6:0] a;
        logic [7:0] d, c;
        logic [2:0] e;
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, NR - 1));
            d = 8'($urandom);
            c = ($urandom_range(0, 1) == 0) ? crc8(a, d) : 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                e = m_write(a, d, c);
                run_op(1, 0, a, d, c, 0, 0);
                nchk++;
                if ({crc_m, wack_m, err_m} !== {(e[2] ? 20'h20000 : 20'h0), (e[1] ? 20'h20000 : 20'h0),
                                               (e[0] ? 20'h20000 : 20'h0)})
                    $display("FAIL rand_wr a=%h d=%h c=%h crc=%h wack=%h err=%h exp %b",
                             a, d, c, crc_m, wack_m, err_m, e);
                else npass++;
            end else begin
                run_op(0, 1, a, 8'h00, 8'h00, 0, 0);
                nchk++;
                if ({rack_m, err_m, rdat, radr} !== {20'h2, (int'(a) >= NR ? 20'h2 : 20'h0), m_read(a), a})
                    $display("FAIL rand_rd a=%h rack=%h err=%h data=%h addr=%h exp data %h",
                             a, rack_m, err_m, rdat, radr, m_read(a));
                else npass++;
            end
        end
        nchk++;
        if ({cfg0, cfg1} !== {mregs[1], mregs[2]})
            $display("FAIL rand_cfg got %h %h exp %h %h", cfg0, cfg1, mregs[1], mregs[2]);
        else npass++;
    endtask

    task automatic test_saturation();
        logic [2:0] e;
        for (int n = 0; n < 300; n++) begin
            e = m_write(7'h04, 8'(n), ~crc8(7'h04, 8'(n)));
            run_op(1, 0, 7'h04, 8'(n), ~crc8(7'h04, 8'(n)), 0, 0);
        end
        run_op(0, 1, 7'h0F, 8'h00, 8'h00, 0, 0);
        nchk++;
        if ({rdat, mcnt} !== {8'hFF, 8'hFF}) $display("FAIL sat_count got %h exp ff", rdat);
        else npass++;
        e = m_write(7'h0F, 8'h9C, crc8(7'h0F, 8'h9C));
        run_op(1, 0, 7'h0F, 8'h9C, crc8(7'h0F, 8'h9C), 0, 0);
        nchk++;
        if ({wack_m, err_m} !== {20'h20000, 20'h0}) $display("FAIL sat_clear_wr wack=%h err=%h", wack_m, err_m);
        else npass++;
        run_op(0, 1, 7'h0F, 8'h00, 8'h00, 0, 0);
        nchk++;
        if (rdat !== 8'h00) $display("FAIL sat_clear got %h exp 00", rdat);
        else npass++;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        run_op(1, 0, 7'h01, 8'h5A, 8'h22, 0, 8);
        nchk++;
        if ({wack_m, crc_m} !== '0) $display("FAIL rst_mid acks wack=%h crc=%h exp 0", wack_m, crc_m);
        else npass++;
        nchk++;
        if (cfg0 !== 8'h00) $display("FAIL rst_mid_cfg0 got %h exp 00", cfg0);
        else npass++;
        // An immediate read proves the FSM is back in IDLE
        run_op(0, 1, 7'h01, 8'h00, 8'h00, 0, 0);
        nchk++;
        if ({rack_m, rdat} !== {20'h2, 8'h00})
            $display("FAIL rst_mid_read rack=%h data=%h exp 00002 00", rack_m, rdat);
        else npass++;
    endtask

    initial begin
        bus.i_spi_reg_wr_req = 1'b0;
        bus.i_spi_reg_rd_req = 1'b0;
        bus.i_spi_reg_addr   = '0;
        bus.i_spi_reg_wdata  = '0;
        bus.i_spi_reg_wcrc   = '0;
        test_reset();
        test_good_write();
        test_bad_crc();
        test_reads();
        test_collisions();
        test_random();
        test_saturation();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
